// File: rtl/bus_demux4.sv
// Single-master to four-slave bus demultiplexer with address decode,
// per-access timeout and a one-cycle registered completion strobe.
module bus_demux4 #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_ready,
  output logic [31:0] m_rdata,
  output logic        m_err,
  output logic [3:0]  s_sel,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata0,
  input  logic [31:0] s_rdata1,
  input  logic [31:0] s_rdata2,
  input  logic [31:0] s_rdata3,
  input  logic [3:0]  s_ack,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

  // Handshake: the master holds m_req and its qualifiers stable until the
  // single-cycle m_ready strobe; a slave completes by raising its s_ack bit
  // while selected, and acks from any other slave are ignored.

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [1:0]  tgt, tgt_n;
  logic [3:0]  sel_n;
  logic        we_n;
  logic [31:0] addr_n;
  logic [31:0] wdata_n;
  logic        ready_n;
  logic        err_n;
  logic [31:0] rdata_n;

  logic        dec_hit;
  logic [1:0]  dec_idx;
  logic [31:0] rd_mux;
  logic        tgt_ack;

  always_comb begin
    dec_hit = 1'b1;
    dec_idx = 2'd0;
    case (m_addr[31:28])
      4'h0:    dec_idx = 2'd0;
      4'h1:    dec_idx = 2'd1;
      4'hE:    dec_idx = 2'd2;
      4'hF:    dec_idx = 2'd3;
      default: dec_hit = 1'b0;
    endcase
  end

  always_comb begin
    rd_mux = s_rdata0;
    case (tgt)
      2'd0: rd_mux = s_rdata0;
      2'd1: rd_mux = s_rdata1;
      2'd2: rd_mux = s_rdata2;
      2'd3: rd_mux = s_rdata3;
      default: rd_mux = s_rdata0;
    endcase
  end

  assign tgt_ack = s_ack[tgt];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tgt_n   = tgt;
    sel_n   = s_sel;
    we_n    = s_we;
    addr_n  = s_addr;
    wdata_n = s_wdata;
    ready_n = 1'b0;
    err_n   = 1'b0;
    rdata_n = 32'd0;

    case (state)
      ST_IDLE: begin
        if (m_req) begin
          we_n    = m_we;
          addr_n  = m_addr;
          wdata_n = m_wdata;
          cnt_n   = 5'd0;
          if (dec_hit) begin
            state_n = ST_ACCESS;
            tgt_n   = dec_idx;
            sel_n   = 4'b0001 << dec_idx;
          end else begin
            state_n = ST_DONE;
            sel_n   = 4'b0000;
            ready_n = 1'b1;
            err_n   = 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        // An ack in the final timeout cycle still takes priority.
        if (tgt_ack) begin
          state_n = ST_DONE;
          sel_n   = 4'b0000;
          ready_n = 1'b1;
          rdata_n = s_we ? 32'd0 : rd_mux;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_DONE;
          sel_n   = 4'b0000;
          ready_n = 1'b1;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = 5'd0;
        sel_n   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cnt     <= 5'd0;
      tgt     <= 2'd0;
      s_sel   <= 4'b0000;
      s_we    <= 1'b0;
      s_addr  <= 32'd0;
      s_wdata <= 32'd0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= 32'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      tgt     <= tgt_n;
      s_sel   <= sel_n;
      s_we    <= we_n;
      s_addr  <= addr_n;
      s_wdata <= wdata_n;
      m_ready <= ready_n;
      m_err   <= err_n;
      m_rdata <= rdata_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/bus_demux4.md
BUS_DEMUX4 -- requirements
Module: bus_demux4

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 16, giving the maximum number of ACCESS cycles before an unacknowledged access is aborted (legal range 2..31).
REQ-002 clk  input  1  Single system clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  Reset, synchronous and active-low; it SHALL be sampled only on the rising clk edge.
REQ-004 m_req  input  1  Master access request; held stable with m_we/m_addr/m_wdata until m_ready.
REQ-005 m_we  input  1  1 = write, 0 = read.
REQ-006 m_addr  input  32  Master byte address.
REQ-007 m_wdata  input  32  Master write data.
REQ-008 m_ready  output  1  One-cycle completion strobe, registered.
REQ-009 m_rdata  output  32  Read data, valid while m_ready=1, registered.
REQ-010 m_err  output  1  Error flag (unmapped or timeout), valid while m_ready=1, registered.
REQ-011 s_sel  output  4  One-hot slave select, registered.
REQ-012 s_we  output  1  Latched write enable to slaves.
REQ-013 s_addr  output  32  Latched address to slaves.
REQ-014 s_wdata  output  32  Latched write data to slaves.
REQ-015 s_rdata0..s_rdata3  input  32 each  Slave read data, sampled on the ack cycle.
REQ-016 s_ack  input  4  Per-slave acknowledge, bit i from slave i.

Function
REQ-017 The decode SHALL use m_addr[31:28]: 0x0 -> slave 0, 0x1 -> slave 1, 0xE -> slave 2, 0xF -> slave 3, and any other value -> unmapped.
REQ-018 The FSM SHALL have the states IDLE, ACCESS and DONE; no other state is reachable, and any illegal encoding SHALL return to IDLE.
REQ-019 IDLE with m_req=1 SHALL latch m_we/m_addr/m_wdata into s_we/s_addr/s_wdata and clear the timeout counter.
- Mapped address: go to ACCESS with s_sel = target one-hot.
- Unmapped address: go directly to DONE with m_err=1, m_rdata=0, and s_sel kept at 0.
REQ-020 In ACCESS, s_sel, s_we, s_addr and s_wdata SHALL hold constant; acks from non-selected slaves SHALL be ignored.
REQ-021 In ACCESS, s_ack[target]=1 SHALL complete the access and go to DONE with m_err=0.
- Read: m_rdata = s_rdataN of the target.
- Write: m_rdata = 0.
- s_sel SHALL clear on the same edge.
REQ-022 The counter SHALL increment on each ACCESS cycle without target ack.
- Counter == TIMEOUT-1 with no ack: go to DONE with m_err=1, m_rdata=0, s_sel cleared.
- Ack arriving in that same final cycle SHALL win, giving a normal completion.
REQ-023 DONE SHALL assert m_ready=1 for exactly one cycle and then return unconditionally to IDLE; m_req is not sampled in DONE.
REQ-024 Outside DONE, m_ready, m_err and m_rdata SHALL be 0.
REQ-025 Latency from the IDLE cycle with m_req=1 to m_ready:
- Unmapped: 1 cycle.
- Ack on the first ACCESS cycle: 2 cycles.
- Maximum: TIMEOUT+1 cycles.
REQ-026 A request held high after m_ready SHALL start a new access on the following IDLE cycle; back-to-back throughput is one access per 3 cycles minimum.

Reset
REQ-027 rstn=0 at a rising edge SHALL force IDLE, counter=0, and m_ready=0, m_err=0, m_rdata=0, s_sel=0, s_we=0, s_addr=0, s_wdata=0, regardless of state.
REQ-028 Reset asserted during ACCESS SHALL abandon the access with no m_ready pulse; a pending s_ack in that cycle SHALL be ignored.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Read 0x1000_0010, s_ack[1] one cycle after s_sel=0010, s_rdata1=0xDEAD_BEEF -> m_ready at +2 cycles, m_rdata=0xDEAD_BEEF, m_err=0.
- Write 0xE000_0000 data 0x0000_00FF, s_ack[2] after 3 ACCESS cycles -> s_we=1, s_wdata=0x0000_00FF held throughout, m_ready at +4, m_rdata=0, m_err=0.
- Read 0x5000_0000 -> s_sel stays 0, m_ready at +1, m_err=1, m_rdata=0.
- Read 0xF000_0004, no ack, TIMEOUT=16 -> s_sel=1000 for exactly 16 cycles, m_ready at +17, m_err=1.
  - Variant: s_ack[3] in cycle 16 -> m_err=0.
- Read 0x0000_0000 with s_ack=0b1110 only (non-target acks) -> no completion until s_ack[0] arrives.
- rstn=0 during ACCESS cycle 2 with s_ack asserted -> next cycle all outputs 0, no m_ready; the next request completes normally.
